// File: rtl/spi_flash_seq.sv
// Command sequencer in front of the SPI flash master: turns CPU requests into
// WREN / PP / SE / READ / RDSR command sequences with WIP polling and timeouts.
module spi_flash_seq #(
    parameter logic [15:0] POLL_MAX = 16'd65535,
    parameter logic [7:0]  POLL_GAP = 8'd16,
    parameter logic [7:0]  START_TO = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] m_data_in,
    output logic [23:0] m_address,
    output logic [7:0]  m_command,
    output logic [2:0]  m_commtype,
    output logic        m_validflag,
    input  logic        m_tready,
    input  logic        m_validflag_out,
    input  logic [31:0] m_data_out
);

    // state      | meaning
    // S_IDLE     | ready for a request
    // S_ISSUE    | load command for current step, pulse validflag once master idle
    // S_WAIT_LOW | wait for master to go busy (start timeout)
    // S_WAIT_DONE| wait for answer pulse or master idle again
    // S_NEXT     | advance step, evaluate WIP poll result
    // S_GAP      | idle spacing between RDSR polls
    // S_RESP     | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_LOW, S_WAIT_DONE, S_NEXT, S_GAP, S_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic [1:0]  step_q;
    logic [23:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;
    logic [15:0] poll_cnt;
    logic [7:0]  timer;
    logic        err_q;

    logic [7:0]  cmd_sel;
    logic [2:0]  type_sel;
    logic        is_pe, last_step, answer_cmd, wip, poll_full, start_tc, gap_tc;

    assign is_pe      = op_q[0] ^ op_q[1];
    assign last_step  = is_pe ? (step_q == 2'd2) : 1'b1;
    assign answer_cmd = (m_commtype == 3'b001) || (m_commtype == 3'b010);
    assign wip        = data_q[24];
    assign poll_full  = ((poll_cnt + 16'd1) == POLL_MAX);
    assign start_tc   = (timer == (START_TO - 8'd1));
    assign gap_tc     = (timer == (POLL_GAP - 8'd1));

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_err   = (state == S_RESP) & err_q;

    always_comb begin
        cmd_sel  = 8'h05;
        type_sel = 3'b001;
        if (op_q == 2'b00) begin
            cmd_sel  = 8'h03;
            type_sel = 3'b010;
        end else if (is_pe && step_q == 2'd0) begin
            cmd_sel  = 8'h06;
            type_sel = 3'b000;
        end else if (is_pe && step_q == 2'd1) begin
            cmd_sel  = (op_q == 2'b01) ? 8'h02 : 8'hD8;
            type_sel = (op_q == 2'b01) ? 3'b100 : 3'b101;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (req_valid) state_nxt = S_ISSUE;
            S_ISSUE:     if (m_tready) state_nxt = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!m_tready)     state_nxt = S_WAIT_DONE;
                else if (start_tc) state_nxt = S_RESP;
            end
            S_WAIT_DONE: if (answer_cmd ? m_validflag_out : m_tready) state_nxt = S_NEXT;
            S_NEXT: begin
                if (!last_step)        state_nxt = S_ISSUE;
                else if (is_pe && wip) state_nxt = poll_full ? S_RESP : S_GAP;
                else                   state_nxt = S_RESP;
            end
            S_GAP:       if (gap_tc) state_nxt = S_ISSUE;
            S_RESP:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= 2'b00;
            step_q      <= 2'd0;
            addr_q      <= 24'd0;
            wdata_q     <= 32'd0;
            data_q      <= 32'd0;
            poll_cnt    <= 16'd0;
            timer       <= 8'd0;
            err_q       <= 1'b0;
            resp_rdata  <= 32'd0;
            m_data_in   <= 32'd0;
            m_address   <= 24'd0;
            m_command   <= 8'd0;
            m_commtype  <= 3'b111;
            m_validflag <= 1'b0;
        end else begin
            m_validflag <= 1'b0;
            case (state)
                S_IDLE: if (req_valid) begin
                    op_q     <= req_op;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    step_q   <= 2'd0;
                    poll_cnt <= 16'd0;
                    timer    <= 8'd0;
                    err_q    <= 1'b0;
                end
                S_ISSUE: if (m_tready) begin
                    m_command   <= cmd_sel;
                    m_commtype  <= type_sel;
                    m_address   <= addr_q;
                    m_data_in   <= wdata_q;
                    m_validflag <= 1'b1;
                    timer       <= 8'd0;
                end
                S_WAIT_LOW: if (m_tready) begin
                    if (start_tc) err_q <= 1'b1;
                    else          timer <= timer + 8'd1;
                end
                S_WAIT_DONE: if (answer_cmd && m_validflag_out) data_q <= m_data_out;
                S_NEXT: begin
                    if (!last_step) begin
                        step_q <= step_q + 2'd1;
                    end else if (is_pe && wip) begin
                        // error path leaves resp_rdata untouched
                        poll_cnt <= poll_cnt + 16'd1;
                        timer    <= 8'd0;
                        if (poll_full) err_q <= 1'b1;
                    end else begin
                        resp_rdata <= data_q;
                    end
                end
                S_GAP: if (!gap_tc) timer <= timer + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_seq.sv
// Directed bench for spi_flash_seq with a small behavioural SPI master model
// that logs every issued command and answers READ/RDSR.
module tb_spi_flash_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] m_data_in;
    logic [23:0] m_address;
    logic [7:0]  m_command;
    logic [2:0]  m_commtype;
    logic        m_validflag;
    logic        m_tready;
    logic        m_validflag_out;
    logic [31:0] m_data_out;

    spi_flash_seq #(
        .POLL_MAX(16'd4),
        .POLL_GAP(8'd16),
        .START_TO(8'd64)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_data_in(m_data_in), .m_address(m_address), .m_command(m_command),
        .m_commtype(m_commtype), .m_validflag(m_validflag), .m_tready(m_tready),
        .m_validflag_out(m_validflag_out), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // master model state
    logic [7:0]  log_cmd  [0:31];
    logic [2:0]  log_type [0:31];
    logic [23:0] log_addr [0:31];
    logic [31:0] log_data [0:31];
    int          log_cyc  [0:31];
    int          log_n = 0;
    logic        no_start = 1'b0;
    int          wip_left = 0;
    logic [31:0] rdsr_idle_word = 32'h0;

    initial begin
        m_tready = 1'b1;
        m_validflag_out = 1'b0;
        m_data_out = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (m_validflag && !rst) begin
                if (log_n < 32) begin
                    log_cmd[log_n]  = m_command;
                    log_type[log_n] = m_commtype;
                    log_addr[log_n] = m_address;
                    log_data[log_n] = m_data_in;
                    log_cyc[log_n]  = cyc;
                    log_n++;
                end
                if (!no_start) begin
                    m_tready = 1'b0;
                    repeat (3) begin @(posedge clk); #1; end
                    if (m_commtype == 3'b001 || m_commtype == 3'b010) begin
                        if (m_commtype == 3'b010) m_data_out = 32'hDEADBEEF;
                        else if (wip_left != 0) begin
                            m_data_out = 32'h0100_0003;
                            if (wip_left > 0) wip_left--;
                        end else m_data_out = rdsr_idle_word;
                        m_validflag_out = 1'b1;
                        @(posedge clk); #1;
                        m_validflag_out = 1'b0;
                    end
                    m_tready = 1'b1;
                end
            end
        end
    end

    logic        rv_seen;
    logic [31:0] rv_data;
    logic        rv_err;
    int          rv_cyc;

    task automatic send_req(input logic [1:0] op, input logic [23:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int limit);
        rv_seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                rv_seen = 1'b1;
                rv_data = resp_rdata;
                rv_err  = resp_err;
                rv_cyc  = cyc;
                break;
            end
        end
        check({tag, "_resp_seen"}, {31'd0, rv_seen}, 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int resp_cnt;
    int log_snap;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_addr = 24'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'd0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_validflag",  {31'd0, m_validflag}, 32'd0);
        check("rst_data_in",    m_data_in, 32'h0);
        check("rst_address",    {8'd0, m_address}, 32'h0);
        check("rst_command",    {24'd0, m_command}, 32'h0);
        check("rst_commtype",   {29'd0, m_commtype}, 32'd7);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // read
        log_n = 0;
        send_req(2'b00, 24'h000100, 32'h0);
        check("rd_ready_drop", {31'd0, req_ready}, 32'd0);
        wait_resp("rd", 200);
        check("rd_rdata", rv_data, 32'hDEADBEEF);
        check("rd_err", {31'd0, rv_err}, 32'd0);
        check("rd_issues", log_n, 1);
        check("rd_cmd", {24'd0, log_cmd[0]}, 32'h03);
        check("rd_type", {29'd0, log_type[0]}, 32'd2);
        check("rd_addr", {8'd0, log_addr[0]}, 32'h000100);
        @(posedge clk); #1;
        check("rd_resp_one_cycle", {31'd0, resp_valid}, 32'd0);
        check("rd_ready_back", {31'd0, req_ready}, 32'd1);

        // read status
        log_n = 0;
        wip_left = 0;
        rdsr_idle_word = 32'h0000_00A5;
        send_req(2'b11, 24'h000000, 32'h0);
        wait_resp("st", 200);
        check("st_rdata", rv_data, 32'h0000_00A5);
        check("st_issues", log_n, 1);
        check("st_cmd", {24'd0, log_cmd[0]}, 32'h05);
        check("st_type", {29'd0, log_type[0]}, 32'd1);

        // program with two WIP polls, plus an ignored request while busy
        repeat (2) @(posedge clk); #1;
        log_n = 0;
        wip_left = 2;
        rdsr_idle_word = 32'h0000_0002;
        send_req(2'b01, 24'h000200, 32'h12345678);
        repeat (5) @(posedge clk); #1;
        req_valid = 1'b1;
        req_op = 2'b00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("pp", 1000);
        repeat (3) @(posedge clk); #1;
        check("pp_err", {31'd0, rv_err}, 32'd0);
        check("pp_rdata", rv_data, 32'h0000_0002);
        check("pp_issues", log_n, 5);
        check("pp_cmd0", {24'd0, log_cmd[0]}, 32'h06);
        check("pp_type0", {29'd0, log_type[0]}, 32'd0);
        check("pp_cmd1", {24'd0, log_cmd[1]}, 32'h02);
        check("pp_type1", {29'd0, log_type[1]}, 32'd4);
        check("pp_addr1", {8'd0, log_addr[1]}, 32'h000200);
        check("pp_data1", log_data[1], 32'h12345678);
        check("pp_cmd2", {24'd0, log_cmd[2]}, 32'h05);
        check("pp_cmd3", {24'd0, log_cmd[3]}, 32'h05);
        check("pp_cmd4", {24'd0, log_cmd[4]}, 32'h05);
        check("pp_gap23", (log_cyc[3] - log_cyc[2] >= 16) ? 32'd1 : 32'd0, 32'd1);
        check("pp_gap34", (log_cyc[4] - log_cyc[3] >= 16) ? 32'd1 : 32'd0, 32'd1);

        // erase with WIP stuck: POLL_MAX polls then error
        log_n = 0;
        wip_left = -1;
        send_req(2'b10, 24'h010000, 32'h0);
        wait_resp("se", 2000);
        repeat (3) @(posedge clk); #1;
        check("se_err", {31'd0, rv_err}, 32'd1);
        check("se_rdata_kept", rv_data, 32'h0000_0002);
        check("se_issues", log_n, 6);
        check("se_cmd0", {24'd0, log_cmd[0]}, 32'h06);
        check("se_cmd1", {24'd0, log_cmd[1]}, 32'hD8);
        check("se_type1", {29'd0, log_type[1]}, 32'd5);
        check("se_cmd5", {24'd0, log_cmd[5]}, 32'h05);
        wip_left = 0;

        // master never starts
        log_n = 0;
        no_start = 1'b1;
        send_req(2'b00, 24'h000300, 32'h0);
        wait_resp("ns", 300);
        check("ns_err", {31'd0, rv_err}, 32'd1);
        check("ns_issues", log_n, 1);
        check("ns_latency", rv_cyc - log_cyc[0], 64);
        check("ns_rdata_kept", rv_data, 32'h0000_0002);
        no_start = 1'b0;
        repeat (2) @(posedge clk); #1;

        // reset mid-poll
        log_n = 0;
        wip_left = 100;
        send_req(2'b01, 24'h000400, 32'hCAFEF00D);
        for (int i = 0; i < 400 && log_n < 4; i++) begin
            @(posedge clk); #1;
        end
        check("mr_reach_poll", (log_n >= 4) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mr_validflag", {31'd0, m_validflag}, 32'd0);
        check("mr_req_ready", {31'd0, req_ready}, 32'd1);
        check("mr_commtype", {29'd0, m_commtype}, 32'd7);
        log_snap = log_n;
        resp_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst = 1'b0;
            if (resp_valid) resp_cnt++;
        end
        check("mr_no_resp", resp_cnt, 0);
        check("mr_no_issue", log_n, log_snap);
        wip_left = 0;

        log_n = 0;
        send_req(2'b00, 24'h000500, 32'h0);
        wait_resp("mr_rd", 200);
        check("mr_rd_rdata", rv_data, 32'hDEADBEEF);
        check("mr_rd_err", {31'd0, rv_err}, 32'd0);
        check("mr_rd_addr", {8'd0, log_addr[0]}, 32'h000500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_seq.md
Name: spi_flash_seq

Overview:
- Command sequencer in front of the SPI flash master. It turns word-level CPU requests into ordered flash command sequences and hands each command to the master through its validflag/commtype/tready interface.
- Supported requests: read, page-program, sector-erase, read-status.
- Program and erase are bracketed by Write Enable and followed by status polling until the flash WIP bit clears.
- Sits between the CPU-side register interface and the SPI flash master.

Parameters:
- POLL_MAX, 16'd65535: maximum RDSR polls before a program/erase aborts with error.
- POLL_GAP, 8'd16: clk cycles idle between consecutive RDSR polls.
- START_TO, 8'd64: clk cycles allowed for master tready to fall after an issue.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  high when IDLE; a request is accepted when req_valid & req_ready.
- req_op  in  2  00 read, 01 program, 10 sector erase, 11 read status.
- req_addr  in  24  flash byte address.
- req_wdata  in  32  program data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  read data / status word.
- resp_err  out  1  qualifies resp_valid: timeout or no-start.
- m_data_in  out  32  to master data_in.
- m_address  out  24  to master address.
- m_command  out  8  to master command.
- m_commtype  out  3  to master commtype.
- m_validflag  out  1  one-cycle issue pulse to master.
- m_tready  in  1  master idle.
- m_validflag_out  in  1  master answer-valid pulse.
- m_data_out  in  32  master answer data.

Behaviour:
- Reset values:
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, m_validflag=0.
  - m_data_in=0, m_address=0, m_command=0, m_commtype=3'b111.
  - State IDLE; step, poll and timer counters 0.
- On acceptance, req_op/req_addr/req_wdata are latched. req_ready drops the next cycle and stays low until the cycle after resp_valid.
- Command table (command, commtype):
  - READ: 0x03, 010.
  - WREN: 0x06, 000.
  - PP: 0x02, 100.
  - SE: 0xD8, 101.
  - RDSR: 0x05, 001.
- Sequences:
  - read: READ.
  - status: RDSR.
  - program: WREN, PP, then RDSR poll loop.
  - erase: WREN, SE, then RDSR poll loop.
- States:
  - IDLE: accept a request. Go to ISSUE.
  - ISSUE: drive m_command/m_commtype/m_address/m_data_in for the current step; pulse m_validflag for exactly 1 cycle, only if m_tready=1, else hold. Go to WAIT_LOW.
  - WAIT_LOW: wait for m_tready=0.
    - Fall seen: go to WAIT_DONE.
    - Timer reaches START_TO: resp_err=1, go to RESP.
  - WAIT_DONE:
    - Answer commands (commtype 001/010): wait for m_validflag_out=1 and capture m_data_out.
    - Other commands: wait for m_tready=1.
    - Then go to NEXT.
  - NEXT:
    - Last step not done: advance step, go to ISSUE.
    - Poll RDSR with WIP=m_data_out[24]=1: poll count +1; go to GAP, or to RESP with resp_err=1 if the count reaches POLL_MAX.
    - WIP=0, or a non-poll final step: go to RESP.
  - GAP: count POLL_GAP cycles, then go to ISSUE (RDSR).
  - RESP: resp_valid=1 for one cycle, with resp_rdata and resp_err valid in the same cycle. Go to IDLE.
- resp_rdata contents:
  - read: READ answer.
  - status, program, erase: the last RDSR word.
  - Not updated on error.
- Outputs to the master are held stable from ISSUE until the next ISSUE; the master samples them late.
- Counters saturate and are never compared past their limit. Poll count and timer are cleared on every request acceptance.
- req_valid while busy is ignored and not queued.
- m_validflag_out outside WAIT_DONE of an answer command is ignored.
- rst asserted mid-sequence returns everything to reset values at once. No resp_valid is produced for the aborted request.

Test Plan:
- Read: req_op=00, addr=0x000100; master model returns 0xDEADBEEF -> one issue with command 0x03, commtype 010, address 0x000100; resp_valid with resp_rdata=0xDEADBEEF, resp_err=0.
- Program: req_op=01, addr=0x000200, wdata=0x12345678; model returns WIP=1 on two polls, then 0 -> issue order 0x06, 0x02, 0x05, 0x05, 0x05; PP address 0x000200, data 0x12345678; ≥POLL_GAP cycles between polls; resp_err=0.
- Erase timeout: POLL_MAX=4, model always returns WIP=1 -> exactly 4 RDSR issues after 0x06, 0xD8; then resp_valid with resp_err=1.
- No-start: model holds m_tready=1 and never falls -> resp_err=1 exactly START_TO cycles after the m_validflag pulse.
- Busy ignore and reset: req_valid pulsed during a program -> no extra issue. rst asserted mid-poll -> m_validflag=0, req_ready=1, no resp_valid; next read request completes normally.
